// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - two-port arbiter/sequencer for the shared 32-bit shifter datapath
// Optional round-robin tie-break selected by SHIFTER_ARB_RR_EN (fixed priority to port 0 otherwise).
module shifter_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [4:0]  count0,
    input  logic [4:0]  count1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [31:0] rsp_data0,
    output logic [31:0] rsp_data1,
    output logic        rsp_err0,
    output logic        rsp_err1,
    input  logic        rsp_ready0,
    input  logic        rsp_ready1,
    output logic [31:0] sh_data_in,
    output logic [4:0]  sh_count,
    output logic [2:0]  sh_op,
    input  logic [31:0] sh_data_out,
    output logic        busy
);

    localparam int N_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [31:0]         data_q, data_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                err_q, err_d;
    logic [31:0]         res_q, res_d;
    logic                last_q, last_d;

    logic [N_PORTS-1:0]  req_vec;
    logic [N_PORTS-1:0]  gnt_vec;
    logic                win;
    logic                owner_ready;

    assign req_vec     = {req1, req0};
    assign owner_ready = owner_q ? rsp_ready1 : rsp_ready0;

    always_comb begin
        win = 1'b0;
`ifdef SHIFTER_ARB_RR_EN
        if (req_vec == 2'b11) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
`else
        win = ~req0;
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        err_d   = err_q;
        res_d   = res_q;
        last_d  = last_q;
        gnt_vec = '0;
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    gnt_vec[win] = 1'b1;
                    op_d    = win ? op1 : op0;
                    data_d  = win ? data1 : data0;
                    cnt_d   = win ? count1 : count0;
                    owner_d = win;
                    err_d   = win ? (op1 > 3'd4) : (op0 > 3'd4);
                    last_d  = win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Masking keeps the error response at zero regardless of shifter behavior.
                res_d   = err_q ? 32'd0 : sh_data_out;
                state_d = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            res_q   <= res_d;
            last_q  <= last_d;
        end
    end

    assign gnt0       = gnt_vec[0];
    assign gnt1       = gnt_vec[1];
    assign busy       = (state_q != IDLE);
    assign rsp_valid0 = (state_q == RESP) && !owner_q;
    assign rsp_valid1 = (state_q == RESP) && owner_q;
    assign rsp_data0  = rsp_valid0 ? res_q : 32'd0;
    assign rsp_data1  = rsp_valid1 ? res_q : 32'd0;
    assign rsp_err0   = rsp_valid0 & err_q;
    assign rsp_err1   = rsp_valid1 & err_q;
    assign sh_data_in = data_q;
    assign sh_count   = cnt_q;
    assign sh_op      = op_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - scoreboard bench for shifter_arbiter with a behavioral shifter
module tb_shifter_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] data0, data1;
    logic [4:0]  count0, count1;
    logic        gnt0, gnt1;
    logic        rsp_valid0, rsp_valid1;
    logic [31:0] rsp_data0, rsp_data1;
    logic        rsp_err0, rsp_err1;
    logic        rsp_ready0, rsp_ready1;
    logic [31:0] sh_data_in;
    logic [4:0]  sh_count;
    logic [2:0]  sh_op;
    logic [31:0] sh_data_out;
    logic        busy;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shifter_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .data0(data0), .data1(data1),
        .count0(count0), .count1(count1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rsp_err0(rsp_err0), .rsp_err1(rsp_err1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .sh_data_in(sh_data_in), .sh_count(sh_count), .sh_op(sh_op),
        .sh_data_out(sh_data_out),
        .busy(busy)
    );

    always_comb begin
        case (sh_op)
            3'd0:    sh_data_out = sh_data_in >> sh_count;
            3'd1:    sh_data_out = $unsigned($signed(sh_data_in) >>> sh_count);
            3'd2:    sh_data_out = sh_data_in << sh_count;
            3'd3:    sh_data_out = (sh_data_in >> sh_count) | (sh_data_in << (6'd32 - {1'b0, sh_count}));
            3'd4:    sh_data_out = (sh_data_in << sh_count) | (sh_data_in >> (6'd32 - {1'b0, sh_count}));
            default: sh_data_out = 32'd0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input logic port, input logic [31:0] d, input logic e);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got response on port %0d expected none", port);
        end else begin
            x = sb.pop_front();
            check("rsp_port", port, x.port);
            check("rsp_data", d, x.data);
            check("rsp_err", e, x.err);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid0 && rsp_ready0) pop_check(1'b0, rsp_data0, rsp_err0);
            if (rsp_valid1 && rsp_ready1) pop_check(1'b1, rsp_data1, rsp_err1);
            if (!rsp_valid0) check("idle_port0", {rsp_err0, rsp_data0}, 64'd0);
            if (!rsp_valid1) check("idle_port1", {rsp_err1, rsp_data1}, 64'd0);
            check("valid_exclusive", rsp_valid0 & rsp_valid1, 0);
            check("gnt_when_busy", (gnt0 | gnt1) & busy, 0);
        end
    end

    task automatic push_exp(input logic port, input logic [31:0] d, input logic e);
        exp_t x;
        x.port = port;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Returns at posedge+1 of the EXEC cycle with the request already dropped.
    task automatic issue(input logic port, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] c, input logic [31:0] exp, input logic do_push);
        logic got;
        if (do_push) push_exp(port, exp, op > 3'd4);
        @(posedge clk); #1;
        if (port) begin req1 = 1'b1; op1 = op; data1 = d; count1 = c; end
        else      begin req0 = 1'b1; op0 = op; data0 = d; count0 = c; end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? gnt1 : gnt0) begin
                got = 1'b1;
                break;
            end
        end
        check("gnt_seen", got, 1);
        @(posedge clk); #1;
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic resp_timing(input logic port);
        @(negedge clk);
        check("exec_busy", busy, 1);
        check("exec_no_valid", rsp_valid0 | rsp_valid1, 0);
        @(negedge clk);
        check("resp_valid", port ? rsp_valid1 : rsp_valid0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        int       last_cyc;
        logic [3:0] order;
        logic     got;

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd0; op1 = 3'd0;
        data0 = 32'd0; data1 = 32'd0;
        count0 = 5'd0; count1 = 5'd0;
        rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", {rsp_valid0, rsp_valid1, rsp_err0, rsp_err1}, 0);
        check("rst_data", {rsp_data0, rsp_data1}, 0);
        check("rst_sh", {sh_data_in, sh_count, sh_op}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(1'b0, 3'd2, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b1);
        resp_timing(1'b0);
        issue(1'b1, 3'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1);
        resp_timing(1'b1);
        issue(1'b1, 3'd3, 32'h0000_00F1, 5'd4, 32'h1000_000F, 1'b1);
        resp_timing(1'b1);
        issue(1'b1, 3'd4, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b1);
        resp_timing(1'b1);
        issue(1'b0, 3'd6, 32'hDEAD_BEEF, 5'd3, 32'h0000_0000, 1'b1);
        resp_timing(1'b0);

        // Contention with both requests held.
`ifdef SHIFTER_ARB_RR_EN
        push_exp(1'b0, 32'h0000_0002, 1'b0);
        push_exp(1'b1, 32'h0000_0010, 1'b0);
        push_exp(1'b0, 32'h0000_0002, 1'b0);
        push_exp(1'b1, 32'h0000_0010, 1'b0);
`else
        for (int k = 0; k < 4; k++) push_exp(1'b0, 32'h0000_0002, 1'b0);
        push_exp(1'b1, 32'h0000_0010, 1'b0);
`endif
        @(posedge clk); #1;
        req0 = 1'b1; op0 = 3'd2; data0 = 32'h0000_0001; count0 = 5'd1;
        req1 = 1'b1; op1 = 3'd0; data1 = 32'h0000_0100; count1 = 5'd4;
        n = 0;
        last_cyc = 0;
        order = 4'b0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                order[n] = gnt1;
                if (n > 0) check("gnt_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                n++;
            end
        end
        check("contention_grants", n, 4);
`ifdef SHIFTER_ARB_RR_EN
        check("contention_order", order, 4'b1010);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
`else
        check("contention_order", order, 4'b0000);
        @(posedge clk); #1;
        req0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt1) begin
                got = 1'b1;
                break;
            end
        end
        check("starved_gnt1", got, 1);
        @(posedge clk); #1;
        req1 = 1'b0;
`endif
        repeat (4) @(negedge clk);

        // Backpressure on port 0 while port 1 waits.
        rsp_ready0 = 1'b0;
        issue(1'b0, 3'd0, 32'hF000_0000, 5'd8, 32'h00F0_0000, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        push_exp(1'b1, 32'h0000_FF00, 1'b0);
        req1 = 1'b1; op1 = 3'd4; data1 = 32'h0000_00FF; count1 = 5'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid0", rsp_valid0, 1);
            check("bp_data0", rsp_data0, 32'h00F0_0000);
            check("bp_gnt1", gnt1, 0);
        end
        @(posedge clk); #1;
        rsp_ready0 = 1'b1;
        @(negedge clk);
        check("bp_release_gnt1", gnt1, 0);
        @(negedge clk);
        check("bp_gnt1_after", gnt1, 1);
        @(posedge clk); #1;
        req1 = 1'b0;
        resp_timing(1'b1);

        // Reset during EXEC discards the operation.
        issue(1'b0, 3'd2, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", rsp_valid0 | rsp_valid1, 0);
        check("rstmid_sh", {sh_data_in, sh_count, sh_op}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(1'b0, 32'h7812_3456, 1'b0);
        req0 = 1'b1; op0 = 3'd3; data0 = 32'h1234_5678; count0 = 5'd8;
        req1 = 1'b1; op1 = 3'd2; data1 = 32'h0000_0001; count1 = 5'd31;
        @(negedge clk);
        check("tie_after_rst", {gnt1, gnt0}, 2'b01);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        resp_timing(1'b0);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
